// File: rtl/sa_job_arbiter.sv
// Round-robin arbiter sharing one systolic array among N_REQ projection jobs.
// Grants a job, steers the operand mux, pulses start, forwards tagged output
// rows and reports completion, with a watchdog for a stalled array.
module sa_job_arbiter #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned X_R     = 64,
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 4096,
  localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned RI_W   = $clog2(X_R)
) (
  input  logic                I_CLK,
  input  logic                I_RST_N,
  input  logic [N_REQ-1:0]    I_REQ,
  output logic [N_REQ-1:0]    O_DONE,
  output logic                O_ERR,
  output logic                O_BUSY,
  output logic [ID_W-1:0]     O_SA_SEL,
  output logic                O_SA_START,
  input  logic                I_SA_OUT_VLD,
  input  logic [64*D_W-1:0]   I_SA_OUT,
  output logic                O_ROW_VLD,
  output logic [64*D_W-1:0]   O_ROW_DATA,
  output logic [RI_W-1:0]     O_ROW_IDX,
  output logic [ID_W-1:0]     O_ROW_ID
);

  localparam int unsigned CW = RI_W + 1;
  localparam int unsigned OW = 64 * D_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   sa_sel_q, sa_sel_d;
  logic              sa_start_q, sa_start_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              row_vld_q, row_vld_d;
  logic [OW-1:0]     row_data_q, row_data_d;
  logic [RI_W-1:0]   row_idx_q, row_idx_d;
  logic [ID_W-1:0]   row_id_q, row_id_d;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [2*N_REQ-1:0] req2_c;
  logic [ID_W-1:0]    pick_c;
  logic               last_beat_c;
  logic               timeout_c;

  assign req2_c      = {I_REQ, I_REQ} >> rr_ptr_q;
  assign last_beat_c = I_SA_OUT_VLD && (row_cnt_q == CW'(X_R - 1));
  assign timeout_c   = !I_SA_OUT_VLD && (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Round-robin pick: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    int  sum;
    logic found;
    pick_c = rr_ptr_q;
    found  = 1'b0;
    sum    = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req2_c[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr_q) + i;
        if (sum >= int'(N_REQ)) sum = sum - int'(N_REQ);
        pick_c = ID_W'(sum);
      end
    end
  end

  // State register.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|I_REQ) state_d = S_GRANT;
      S_GRANT: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (last_beat_c || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; done/err are set on entry to DONE so
  // they are visible during the DONE cycle together with the last row.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    sa_sel_d   = sa_sel_q;
    sa_start_d = 1'b0;
    done_d     = '0;
    err_d      = 1'b0;
    busy_d     = (state_d != S_IDLE);
    row_vld_d  = 1'b0;
    row_data_d = row_data_q;
    row_idx_d  = row_idx_q;
    row_id_d   = row_id_q;
    row_cnt_d  = row_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|I_REQ) sa_sel_d = pick_c;
      end
      S_GRANT: begin
        sa_start_d = 1'b1;
      end
      S_START: begin
        row_cnt_d = '0;
        to_cnt_d  = '0;
      end
      S_RUN: begin
        if (I_SA_OUT_VLD) begin
          row_vld_d  = 1'b1;
          row_data_d = I_SA_OUT;
          row_idx_d  = row_cnt_q[RI_W-1:0];
          row_id_d   = sa_sel_q;
          row_cnt_d  = row_cnt_q + CW'(1);
          to_cnt_d   = '0;
          if (last_beat_c) done_d = N_REQ'(1) << sa_sel_q;
        end else begin
          if (to_cnt_q != {TO_W{1'b1}}) to_cnt_d = to_cnt_q + TO_W'(1);
          if (timeout_c) begin
            done_d = N_REQ'(1) << sa_sel_q;
            err_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        rr_ptr_d = (sa_sel_q == ID_W'(N_REQ - 1)) ? '0 : sa_sel_q + ID_W'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      rr_ptr_q   <= '0;
      sa_sel_q   <= '0;
      sa_start_q <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      row_vld_q  <= 1'b0;
      row_data_q <= '0;
      row_idx_q  <= '0;
      row_id_q   <= '0;
      row_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      sa_sel_q   <= sa_sel_d;
      sa_start_q <= sa_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      row_vld_q  <= row_vld_d;
      row_data_q <= row_data_d;
      row_idx_q  <= row_idx_d;
      row_id_q   <= row_id_d;
      row_cnt_q  <= row_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign O_DONE     = done_q;
  assign O_ERR      = err_q;
  assign O_BUSY     = busy_q;
  assign O_SA_SEL   = sa_sel_q;
  assign O_SA_START = sa_start_q;
  assign O_ROW_VLD  = row_vld_q;
  assign O_ROW_DATA = row_data_q;
  assign O_ROW_IDX  = row_idx_q;
  assign O_ROW_ID   = row_id_q;

endmodule

// File: tb/tb_sa_job_arbiter.sv
// Directed bench for sa_job_arbiter (X_R=64, N_REQ=3, TIMEOUT=16).
module tb_sa_job_arbiter;

  localparam int unsigned D_W  = 8;
  localparam int unsigned X_R  = 64;
  localparam int unsigned N_REQ = 3;
  localparam int unsigned TO   = 16;
  localparam int unsigned ID_W = 2;
  localparam int unsigned RI_W = 6;
  localparam int MAXIT = 400;

  logic              I_CLK = 1'b0;
  logic              I_RST_N = 1'b0;
  logic [2:0]        I_REQ = '0;
  logic [2:0]        O_DONE;
  logic              O_ERR, O_BUSY;
  logic [ID_W-1:0]   O_SA_SEL;
  logic              O_SA_START;
  logic              I_SA_OUT_VLD = 1'b0;
  logic [511:0]      I_SA_OUT = '0;
  logic              O_ROW_VLD;
  logic [511:0]      O_ROW_DATA;
  logic [RI_W-1:0]   O_ROW_IDX;
  logic [ID_W-1:0]   O_ROW_ID;

  int tests = 0;
  int fails = 0;

  // observations of the last run_job
  int          r_start_it, r_rows, r_rows_ok, r_done_rel, r_nstart;
  logic [2:0]  r_done;
  logic        r_err;
  logic [1:0]  r_sel, r_prev_sel;

  sa_job_arbiter #(.D_W(D_W), .X_R(X_R), .N_REQ(N_REQ), .TO_W(16), .TIMEOUT(TO)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_REQ(I_REQ), .O_DONE(O_DONE), .O_ERR(O_ERR),
    .O_BUSY(O_BUSY), .O_SA_SEL(O_SA_SEL), .O_SA_START(O_SA_START),
    .I_SA_OUT_VLD(I_SA_OUT_VLD), .I_SA_OUT(I_SA_OUT), .O_ROW_VLD(O_ROW_VLD),
    .O_ROW_DATA(O_ROW_DATA), .O_ROW_IDX(O_ROW_IDX), .O_ROW_ID(O_ROW_ID)
  );

  always #5 I_CLK = ~I_CLK;

  function automatic logic [511:0] pat(input int b);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 64; j++) v[j*8 +: 8] = 8'(b * 5 + j * 3 + 1);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge I_CLK);
    I_RST_N = 1'b0; I_REQ = '0; I_SA_OUT_VLD = 1'b0;
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
  endtask

  // Drive one job and record what the DUT does; beats on RUN cycles c where c%gap==gap-1.
  task automatic run_job(input logic [2:0] req, input logic [2:0] req_after, input int nbeats,
                         input int gap, input bit stray, input int drop_row,
                         input logic [2:0] drop_req, input int abort_row);
    int s, sent, c;
    logic [1:0] prev_sel;
    logic beat;
    r_start_it = -1; r_rows = 0; r_rows_ok = 0; r_done_rel = -1; r_nstart = 0;
    r_done = '0; r_err = 1'b0; r_sel = '0; r_prev_sel = '0;
    s = -1; sent = 0; prev_sel = O_SA_SEL;
    I_REQ = req; I_SA_OUT_VLD = stray;
    for (int it = 1; it <= MAXIT; it++) begin
      @(negedge I_CLK);
      if (O_SA_START) begin
        r_nstart++;
        if (s < 0) begin s = it; r_start_it = it; r_sel = O_SA_SEL; r_prev_sel = prev_sel; end
      end
      prev_sel = O_SA_SEL;
      if (O_ROW_VLD) begin
        if (O_ROW_IDX == RI_W'(r_rows) && O_ROW_ID == r_sel && O_ROW_DATA == pat(r_rows))
          r_rows_ok++;
        r_rows++;
      end
      if (O_DONE != '0) begin
        r_done = O_DONE; r_err = O_ERR; r_done_rel = it - s;
        I_REQ = req_after; I_SA_OUT_VLD = stray;
        return;
      end
      if (abort_row >= 0 && r_rows == abort_row) return;
      if (drop_row >= 0 && r_rows == drop_row) I_REQ = drop_req;
      if (s < 0 || it == s) begin
        I_SA_OUT_VLD = stray;
      end else begin
        c = it - s - 1;
        beat = (sent < nbeats) && ((c % gap) == gap - 1);
        I_SA_OUT_VLD = beat;
        if (beat) begin I_SA_OUT = pat(sent); sent++; end
      end
    end
    tests++; fails++;
    $display("FAIL run_job_budget: no O_DONE within %0d cycles (starts=%0d rows=%0d)", MAXIT, r_nstart, r_rows);
  endtask

  task automatic test_reset();
    @(negedge I_CLK);
    I_RST_N = 1'b0; I_REQ = 3'b111; I_SA_OUT_VLD = 1'b1;
    #1;
    tests++;
    if ({O_DONE, O_ERR, O_BUSY, O_SA_SEL, O_SA_START, O_ROW_VLD, O_ROW_IDX, O_ROW_ID} !== '0
        || O_ROW_DATA !== '0) begin
      fails++;
      $display("FAIL reset_outputs: done=%b err=%b busy=%b sel=%0d start=%b vld=%b idx=%0d id=%0d required all 0",
               O_DONE, O_ERR, O_BUSY, O_SA_SEL, O_SA_START, O_ROW_VLD, O_ROW_IDX, O_ROW_ID);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    run_job(3'b010, 3'b000, 64, 3, 1'b0, -1, 3'b000, -1);
    tests++; if (r_sel !== 2'd1)      begin fails++; $display("FAIL t1_sel: got %0d need 1", r_sel); end
    tests++; if (r_prev_sel !== 2'd1) begin fails++; $display("FAIL t1_sel_pre_start: got %0d need 1", r_prev_sel); end
    tests++; if (r_start_it != 2)     begin fails++; $display("FAIL t1_start_latency: got %0d need 2", r_start_it); end
    tests++; if (r_nstart != 1)       begin fails++; $display("FAIL t1_start_count: got %0d need 1", r_nstart); end
    tests++; if (r_rows != 64 || r_rows_ok != 64)
      begin fails++; $display("FAIL t1_rows: got %0d rows %0d correct need 64", r_rows, r_rows_ok); end
    tests++; if (r_done !== 3'b010 || r_err !== 1'b0)
      begin fails++; $display("FAIL t1_done: got done=%b err=%b need 010/0", r_done, r_err); end
    tests++; if (r_done_rel != 193)   begin fails++; $display("FAIL t1_done_time: got %0d need 193", r_done_rel); end
    @(negedge I_CLK);
    tests++; if (O_BUSY !== 1'b0 || O_DONE !== 3'b000 || O_ROW_VLD !== 1'b0)
      begin fails++; $display("FAIL t1_idle_after: busy=%b done=%b vld=%b need 0", O_BUSY, O_DONE, O_ROW_VLD); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [1:0] exp_b [3] = '{2'd2, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_job(3'b111, (k == 3) ? 3'b010 : 3'b111, 64, 1, 1'b0, -1, 3'b000, -1);
      tests++;
      if (r_sel !== exp_a[k] || r_done !== (3'b001 << exp_a[k]))
        begin fails++; $display("FAIL t2_rr_a%0d: sel=%0d done=%b need sel %0d", k, r_sel, r_done, exp_a[k]); end
    end
    run_job(3'b010, 3'b111, 64, 1, 1'b0, -1, 3'b000, -1);
    tests++; if (r_sel !== 2'd1) begin fails++; $display("FAIL t2_req1_only: got %0d need 1", r_sel); end
    for (int k = 0; k < 3; k++) begin
      run_job(3'b111, (k == 2) ? 3'b000 : 3'b111, 64, 1, 1'b0, -1, 3'b000, -1);
      tests++;
      if (r_sel !== exp_b[k] || r_rows_ok != 64)
        begin fails++; $display("FAIL t2_rr_b%0d: sel=%0d rows_ok=%0d need sel %0d", k, r_sel, r_rows_ok, exp_b[k]); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_job(3'b001, 3'b000, 0, 1, 1'b0, -1, 3'b000, -1);
    tests++; if (r_done !== 3'b001 || r_err !== 1'b1)
      begin fails++; $display("FAIL t3_to_flags: done=%b err=%b need 001/1", r_done, r_err); end
    tests++; if (r_done_rel != 17 || r_rows != 0)
      begin fails++; $display("FAIL t3_to_time: rel=%0d rows=%0d need 17/0", r_done_rel, r_rows); end
    @(negedge I_CLK);
    tests++; if (O_ERR !== 1'b0) begin fails++; $display("FAIL t3_err_pulse: err=%b need 0", O_ERR); end
    run_job(3'b001, 3'b000, 5, 3, 1'b0, -1, 3'b000, -1);
    tests++; if (r_err !== 1'b1 || r_rows != 5 || r_rows_ok != 5 || r_done_rel != 32)
      begin fails++; $display("FAIL t3_to_after5: err=%b rows=%0d ok=%0d rel=%0d need 1/5/5/32", r_err, r_rows, r_rows_ok, r_done_rel); end
  endtask

  task automatic test_stray_beats();
    int seen;
    do_reset();
    seen = 0;
    I_SA_OUT_VLD = 1'b1; I_SA_OUT = pat(99);
    repeat (4) begin @(negedge I_CLK); if (O_ROW_VLD) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL t4_idle_stray: got %0d rows need 0", seen); end
    run_job(3'b100, 3'b000, 64, 2, 1'b1, -1, 3'b000, -1);
    tests++; if (r_rows != 64 || r_rows_ok != 64 || r_done !== 3'b100 || r_done_rel != 129)
      begin fails++; $display("FAIL t4_job: rows=%0d ok=%0d done=%b rel=%0d need 64/64/100/129", r_rows, r_rows_ok, r_done, r_done_rel); end
    @(negedge I_CLK);
    tests++; if (O_ROW_VLD !== 1'b0) begin fails++; $display("FAIL t4_done_stray: vld=%b need 0", O_ROW_VLD); end
    I_SA_OUT_VLD = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    run_job(3'b010, 3'b000, 64, 1, 1'b0, -1, 3'b000, -1);
    run_job(3'b100, 3'b100, 64, 1, 1'b0, -1, 3'b000, 30);
    tests++; if (r_rows != 30) begin fails++; $display("FAIL t5_reach30: rows=%0d need 30", r_rows); end
    I_RST_N = 1'b0; I_SA_OUT_VLD = 1'b0;
    #1;
    tests++;
    if ({O_DONE, O_ERR, O_BUSY, O_SA_SEL, O_SA_START, O_ROW_VLD, O_ROW_IDX, O_ROW_ID} !== '0
        || O_ROW_DATA !== '0) begin
      fails++;
      $display("FAIL t5_async_reset: busy=%b sel=%0d vld=%b idx=%0d id=%0d required all 0",
               O_BUSY, O_SA_SEL, O_ROW_VLD, O_ROW_IDX, O_ROW_ID);
    end
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    run_job(3'b101, 3'b000, 64, 1, 1'b0, -1, 3'b000, -1);
    tests++; if (r_sel !== 2'd0) begin fails++; $display("FAIL t5_rr_cleared: sel=%0d need 0", r_sel); end
    run_job(3'b100, 3'b000, 64, 1, 1'b0, -1, 3'b000, -1);
    tests++; if (r_sel !== 2'd2 || r_rows_ok != 64 || r_done !== 3'b100)
      begin fails++; $display("FAIL t5_clean_job: sel=%0d ok=%0d done=%b need 2/64/100", r_sel, r_rows_ok, r_done); end
  endtask

  task automatic test_req_drop();
    do_reset();
    run_job(3'b001, 3'b000, 64, 1, 1'b0, 10, 3'b000, -1);
    tests++; if (r_rows != 64 || r_rows_ok != 64 || r_done !== 3'b001 || r_err !== 1'b0)
      begin fails++; $display("FAIL t6_drop: rows=%0d ok=%0d done=%b err=%b need 64/64/001/0", r_rows, r_rows_ok, r_done, r_err); end
    repeat (3) @(negedge I_CLK);
    tests++; if (O_BUSY !== 1'b0) begin fails++; $display("FAIL t6_no_regrant: busy=%b need 0", O_BUSY); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stray_beats();
    test_reset_mid_run();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
